// File: rtl/ps_ureg_pkg.sv
// Shared constants for the PS universal-register space: address map, STKY bit
// positions and default sizes. The ureg decoder imports this package too.
package ps_ureg_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_STK_DEPTH = 8;

    localparam logic [4:0] ADDR_NULL   = 5'h00;
    localparam logic [4:0] ADDR_STACK  = 5'h04;
    localparam logic [4:0] ADDR_STKPTR = 5'h05;
    localparam logic [4:0] ADDR_STKY   = 5'h06;

    localparam int STKY_OVF   = 0;
    localparam int STKY_UNF   = 1;
    localparam int STKY_EMPTY = 2;
    localparam int STKY_FULL  = 3;

    function automatic logic is_gen_reg(input logic [4:0] addr);
        return (addr != ADDR_NULL) && (addr != ADDR_STACK) &&
               (addr != ADDR_STKPTR) && (addr != ADDR_STKY);
    endfunction

endpackage

// File: rtl/ps_ureg_stack.sv
// Hardware stack behind the STACK/STKPTR/STKY registers: storage, a
// non-wrapping pointer, level flags and sticky overflow/underflow flags.
module ps_ureg_stack
    import ps_ureg_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int STK_DEPTH = DEF_STK_DEPTH,
    parameter int PTR_W     = $clog2(STK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pop,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] top_dat,
    output logic [PTR_W-1:0]  ptr,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);

    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(STK_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-2:0] IDX_ONE  = (PTR_W-1)'(1);

    logic [DATA_W-1:0] mem_q [STK_DEPTH];
    logic [DATA_W-1:0] mem_d [STK_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_mid_s;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              pop_ok_s, push_ok_s;
    logic [PTR_W-2:0]  top_idx_s;

    assign empty     = (ptr_q == '0);
    assign full      = (ptr_q == PTR_FULL);
    assign ptr       = ptr_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign top_idx_s = ptr_q[PTR_W-2:0] - IDX_ONE;
    assign top_dat   = empty ? '0 : mem_q[top_idx_s];

    // Pop is applied before push, so a pop+push on a full stack has room.
    always_comb begin
        mem_d     = mem_q;
        pop_ok_s  = pop && !empty;
        ptr_mid_s = pop_ok_s ? (ptr_q - PTR_ONE) : ptr_q;
        push_ok_s = push && (ptr_mid_s != PTR_FULL);
        ptr_d     = push_ok_s ? (ptr_mid_s + PTR_ONE) : ptr_mid_s;
        if (push_ok_s) begin
            mem_d[ptr_mid_s[PTR_W-2:0]] = push_dat;
        end else begin
            mem_d = mem_q;
        end
        // A flag event in the same cycle as a STKY write wins over the clear.
        ovf_d = (push && !push_ok_s) || (ovf_q && !clr_flags);
        unf_d = (pop && empty) || (unf_q && !clr_flags);
    end

    // Stack state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STK_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

endmodule

// File: rtl/ps_ureg_file.sv
// PS universal-register file: general registers, address decode and the
// combinational read mux over the general registers and the stack.
module ps_ureg_file
    import ps_ureg_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int STK_DEPTH = DEF_STK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ps_rd_add,
    input  logic              ps_popstck,
    input  logic [4:0]        ps_wrt_add,
    input  logic              ps_wrt_en,
    input  logic [DATA_W-1:0] ps_wrt_dat,
    output logic [DATA_W-1:0] ps_rd_dat,
    output logic              ps_stk_empty,
    output logic              ps_stk_full,
    output logic              ps_stk_ovf,
    output logic              ps_stk_unf
);

    localparam int PTR_W = $clog2(STK_DEPTH) + 1;

    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];
    logic [DATA_W-1:0] top_dat_s;
    logic [PTR_W-1:0]  ptr_s;
    logic              pop_s, push_s, clr_s;

    assign pop_s  = ps_popstck && (ps_rd_add == ADDR_STACK);
    assign push_s = ps_wrt_en && (ps_wrt_add == ADDR_STACK);
    assign clr_s  = ps_wrt_en && (ps_wrt_add == ADDR_STKY);

    ps_ureg_stack #(
        .DATA_W    (DATA_W),
        .STK_DEPTH (STK_DEPTH),
        .PTR_W     (PTR_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .pop       (pop_s),
        .push      (push_s),
        .push_dat  (ps_wrt_dat),
        .clr_flags (clr_s),
        .top_dat   (top_dat_s),
        .ptr       (ptr_s),
        .empty     (ps_stk_empty),
        .full      (ps_stk_full),
        .ovf       (ps_stk_ovf),
        .unf       (ps_stk_unf)
    );

    // Next state of the general registers; special addresses are never stored.
    always_comb begin
        regs_d = regs_q;
        if (ps_wrt_en && is_gen_reg(ps_wrt_add)) begin
            regs_d[ps_wrt_add] = ps_wrt_dat;
        end else begin
            regs_d = regs_q;
        end
    end

    // General register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read mux; reads the registered state only, so a same-cycle write is not visible.
    always_comb begin
        ps_rd_dat = '0;
        case (ps_rd_add)
            ADDR_NULL:   ps_rd_dat = '0;
            ADDR_STACK:  ps_rd_dat = top_dat_s;
            ADDR_STKPTR: ps_rd_dat[PTR_W-1:0] = ptr_s;
            ADDR_STKY: begin
                ps_rd_dat[STKY_OVF]   = ps_stk_ovf;
                ps_rd_dat[STKY_UNF]   = ps_stk_unf;
                ps_rd_dat[STKY_EMPTY] = ps_stk_empty;
                ps_rd_dat[STKY_FULL]  = ps_stk_full;
            end
            default:     ps_rd_dat = regs_q[ps_rd_add];
        endcase
    end

endmodule

// File: tb/tb_ps_ureg_file.sv
// Directed bench for ps_ureg_file: register file, stack push/pop, flags, reset.
module tb_ps_ureg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  ps_rd_add;
    logic        ps_popstck;
    logic [4:0]  ps_wrt_add;
    logic        ps_wrt_en;
    logic [15:0] ps_wrt_dat;
    logic [15:0] ps_rd_dat;
    logic        ps_stk_empty, ps_stk_full, ps_stk_ovf, ps_stk_unf;

    int n_total;
    int n_pass;

    ps_ureg_file #(.DATA_W(16), .STK_DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps_rd_add    (ps_rd_add),
        .ps_popstck   (ps_popstck),
        .ps_wrt_add   (ps_wrt_add),
        .ps_wrt_en    (ps_wrt_en),
        .ps_wrt_dat   (ps_wrt_dat),
        .ps_rd_dat    (ps_rd_dat),
        .ps_stk_empty (ps_stk_empty),
        .ps_stk_full  (ps_stk_full),
        .ps_stk_ovf   (ps_stk_ovf),
        .ps_stk_unf   (ps_stk_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        ps_wrt_add = a;
        ps_wrt_dat = d;
        ps_wrt_en  = 1'b1;
        tick();
        ps_wrt_en  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [15:0] exp);
        ps_rd_add = a;
        #1;
        chk(tag, ps_rd_dat, exp);
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] exp);
        ps_rd_add  = 5'h04;
        ps_popstck = 1'b1;
        #1;
        chk(tag, ps_rd_dat, exp);
        tick();
        ps_popstck = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1; ps_rd_add = 5'h00; ps_popstck = 1'b0;
        ps_wrt_add = 5'h00; ps_wrt_en = 1'b0; ps_wrt_dat = 16'h0000;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_empty", ps_stk_empty, 1);
        chk("rst_full", ps_stk_full, 0);
        chk("rst_flags", {ps_stk_ovf, ps_stk_unf}, 0);
        rd("rst_ptr", 5'h05, 16'h0000);

        // general register: old value same cycle, new value next cycle
        ps_rd_add = 5'h09; ps_wrt_add = 5'h09; ps_wrt_dat = 16'hA5A5; ps_wrt_en = 1'b1;
        #1;
        chk("wr_nobypass", ps_rd_dat, 16'h0000);
        tick();
        ps_wrt_en = 1'b0;
        rd("wr_rd09", 5'h09, 16'hA5A5);
        wr(5'h1F, 16'h1234);
        rd("wr_rd1f", 5'h1F, 16'h1234);
        wr(5'h00, 16'hFFFF);
        rd("null_rd", 5'h00, 16'h0000);
        wr(5'h05, 16'h0003);
        rd("stkptr_ro", 5'h05, 16'h0000);

        // fill to full, then overflow
        for (int i = 1; i <= 8; i++) wr(5'h04, 16'(i));
        chk("fill_full", ps_stk_full, 1);
        rd("fill_ptr", 5'h05, 16'h0008);
        rd("fill_stky", 5'h06, 16'h0008);
        wr(5'h04, 16'h0009);
        chk("ovf_flag", ps_stk_ovf, 1);
        rd("ovf_ptr", 5'h05, 16'h0008);
        pop_chk("ovf_pop", 16'h0008);
        rd("pop_ptr", 5'h05, 16'h0007);

        // plain STACK read does not move the pointer
        rd("peek_top", 5'h04, 16'h0007);
        tick();
        rd("peek_ptr", 5'h05, 16'h0007);
        rd("stky_ovf", 5'h06, 16'h0001);
        wr(5'h06, 16'h0000);
        chk("ovf_clr", ps_stk_ovf, 0);

        // drain, then pop on empty
        for (int i = 7; i >= 1; i--) pop_chk("drain", 16'(i));
        chk("drain_empty", ps_stk_empty, 1);
        pop_chk("unf_rd", 16'h0000);
        chk("unf_flag", ps_stk_unf, 1);
        rd("unf_ptr", 5'h05, 16'h0000);
        rd("stky_unf", 5'h06, 16'h0006);
        wr(5'h06, 16'h0000);
        chk("unf_clr", {ps_stk_ovf, ps_stk_unf}, 0);

        // underflow event wins over a same-cycle STKY clear
        ps_wrt_add = 5'h06; ps_wrt_en = 1'b1;
        pop_chk("unf_win_rd", 16'h0000);
        ps_wrt_en = 1'b0;
        chk("unf_win", ps_stk_unf, 1);
        wr(5'h06, 16'h0000);

        // simultaneous pop+push with {3,7}
        wr(5'h04, 16'h0003);
        wr(5'h04, 16'h0007);
        ps_wrt_add = 5'h04; ps_wrt_dat = 16'h0011; ps_wrt_en = 1'b1;
        pop_chk("pp_rd", 16'h0007);
        ps_wrt_en = 1'b0;
        rd("pp_top", 5'h04, 16'h0011);
        rd("pp_ptr", 5'h05, 16'h0002);
        pop_chk("pp_pop1", 16'h0011);
        pop_chk("pp_pop2", 16'h0003);

        // simultaneous pop+push on empty
        ps_wrt_add = 5'h04; ps_wrt_dat = 16'h0042; ps_wrt_en = 1'b1;
        pop_chk("ppe_rd", 16'h0000);
        ps_wrt_en = 1'b0;
        chk("ppe_unf", ps_stk_unf, 1);
        rd("ppe_ptr", 5'h05, 16'h0001);
        rd("ppe_top", 5'h04, 16'h0042);
        wr(5'h06, 16'h0000);

        // simultaneous pop+push on full: no overflow
        for (int i = 2; i <= 8; i++) wr(5'h04, 16'(i + 16'h0100));
        chk("ppf_full", ps_stk_full, 1);
        ps_wrt_add = 5'h04; ps_wrt_dat = 16'h0BEE; ps_wrt_en = 1'b1;
        pop_chk("ppf_rd", 16'h0108);
        ps_wrt_en = 1'b0;
        chk("ppf_noovf", ps_stk_ovf, 0);
        rd("ppf_ptr", 5'h05, 16'h0008);
        rd("ppf_top", 5'h04, 16'h0BEE);

        // reset asserted mid-push with pointer at 5
        for (int i = 0; i < 3; i++) pop_chk("pre_rst_pop", (i == 0) ? 16'h0BEE : 16'(16'h0107 - i + 1));
        rd("pre_rst_ptr", 5'h05, 16'h0005);
        ps_wrt_add = 5'h04; ps_wrt_dat = 16'h0777; ps_wrt_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_ptr", ps_stk_empty, 1);
        tick();
        ps_wrt_en = 1'b0;
        rst = 1'b0;
        rd("rst_ptr2", 5'h05, 16'h0000);
        chk("rst_empty2", ps_stk_empty, 1);
        rd("rst_reg09", 5'h09, 16'h0000);
        rd("rst_reg1f", 5'h1F, 16'h0000);
        rd("rst_stack", 5'h04, 16'h0000);
        wr(5'h04, 16'h0055);
        rd("post_rst_ptr", 5'h05, 16'h0001);
        rd("post_rst_top", 5'h04, 16'h0055);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
